hazard_unit: RTL and testbench

Pipeline hazard controller for the 5-stage RV32 core. Resolves every hazard that operand forwarding cannot: load-use, multi-cycle (MDU) result dependencies and taken-branch squashes. Sits beside the ID/EX boundary and drives the stall/flush controls of PC, IF/ID and ID/EX. Keeps a registered scoreboard of in-flight long-latency destinations plus a stall-cycle counter.

---
 rtl/hazard_pkg.sv | 13 +
 rtl/hazard_scoreboard.sv | 43 ++++
 rtl/hazard_unit.sv | 91 +++++++++
 tb/tb_hazard_unit.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared widths and debug encodings for the pipeline hazard controller.
package hazard_pkg;
  localparam int REG_AW_DEF = 5;
  localparam int CNT_W_DEF  = 32;

  typedef enum logic [2:0] {
    CAUSE_NONE,
    CAUSE_LOAD_USE,
    CAUSE_RAW_LONG,
    CAUSE_WAW_LONG,
    CAUSE_STRUCT
  } stall_cause_e;
endpackage

// File: rtl/hazard_scoreboard.sv
// Tracks the single outstanding MDU op: busy flag, pending destination bits
// and a sticky error for writebacks that arrive with nothing outstanding.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     issue,
  input  logic                     issue_wr,
  input  logic [REG_AW-1:0]        issue_rd,
  input  logic                     wb_valid,
  input  logic [REG_AW-1:0]        wb_rd,
  output logic [(1<<REG_AW)-1:0]   pending,
  output logic                     lop_busy,
  output logic                     lop_err
);

  // issue is only possible while not busy, so a writeback and an issue
  // never touch the scoreboard in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending  <= '0;
      lop_busy <= 1'b0;
      lop_err  <= 1'b0;
    end else begin
      if (wb_valid) begin
        if (lop_busy) begin
          lop_busy         <= 1'b0;
          pending[wb_rd]   <= 1'b0;
        end else begin
          lop_err <= 1'b1;
        end
      end
      if (issue) begin
        lop_busy <= 1'b1;
        if (issue_wr) pending[issue_rd] <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Stall/flush decode for load-use, MDU scoreboard and branch squash hazards,
// plus a saturating count of stall cycles.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [REG_AW-1:0]        rs1_id,
  input  logic [REG_AW-1:0]        rs2_id,
  input  logic                     rs1_used_id,
  input  logic                     rs2_used_id,
  input  logic [REG_AW-1:0]        rd_id,
  input  logic                     regWrite_id,
  input  logic                     longOp_id,
  input  logic [REG_AW-1:0]        rd_ex,
  input  logic                     memRead_ex,
  input  logic                     branchTaken_ex,
  input  logic                     lop_wb_valid,
  input  logic [REG_AW-1:0]        lop_wb_rd,
  output logic                     stallPC,
  output logic                     stallIFID,
  output logic                     flushIFID,
  output logic                     flushIDEX,
  output logic                     lop_busy,
  output logic [(1<<REG_AW)-1:0]   pending,
  output logic [CNT_W-1:0]         stall_cycles,
  output logic                     lop_err
);

  logic         load_use, raw_long, waw_long, struct_haz;
  logic         stall, issue, rd_nz;
  stall_cause_e cause;

  assign rd_nz = (rd_id != '0);

  always_comb begin
    load_use   = memRead_ex && (rd_ex != '0) &&
                 ((rs1_used_id && rs1_id == rd_ex) || (rs2_used_id && rs2_id == rd_ex));
    // pending[0] is never set, so x0 sources cannot raise a RAW stall.
    raw_long   = (rs1_used_id && pending[rs1_id]) || (rs2_used_id && pending[rs2_id]);
    waw_long   = regWrite_id && rd_nz && pending[rd_id];
    struct_haz = longOp_id && lop_busy;

    cause = CAUSE_NONE;
    if      (load_use)   cause = CAUSE_LOAD_USE;
    else if (raw_long)   cause = CAUSE_RAW_LONG;
    else if (waw_long)   cause = CAUSE_WAW_LONG;
    else if (struct_haz) cause = CAUSE_STRUCT;

    stall = (cause != CAUSE_NONE);
    issue = longOp_id && !stall && !branchTaken_ex;

    stallPC   = 1'b0;
    stallIFID = 1'b0;
    flushIFID = 1'b0;
    flushIDEX = 1'b0;
    if (branchTaken_ex) begin
      flushIFID = 1'b1;
      flushIDEX = 1'b1;
    end else if (stall) begin
      stallPC   = 1'b1;
      stallIFID = 1'b1;
      flushIDEX = 1'b1;
    end
  end

  hazard_scoreboard #(.REG_AW(REG_AW)) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .issue    (issue),
    .issue_wr (regWrite_id && rd_nz),
    .issue_rd (rd_id),
    .wb_valid (lop_wb_valid),
    .wb_rd    (lop_wb_rd),
    .pending  (pending),
    .lop_busy (lop_busy),
    .lop_err  (lop_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (stall && !branchTaken_ex && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed and random checks of hazard_unit against a register-level model.
module tb_hazard_unit;
  localparam int AW = 5;
  localparam int CW = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] rs1_id, rs2_id, rd_id, rd_ex, lop_wb_rd;
  logic          rs1_used_id, rs2_used_id, regWrite_id, longOp_id;
  logic          memRead_ex, branchTaken_ex, lop_wb_valid;
  logic          stallPC, stallIFID, flushIFID, flushIDEX, lop_busy, lop_err;
  logic [31:0]   pending;
  logic [CW-1:0] stall_cycles;

  int checks = 0;
  int failures = 0;

  // reference model state
  bit m_pend [32];
  bit m_busy, m_err;
  int m_cnt;

  hazard_unit #(.REG_AW(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_id(rs1_id), .rs2_id(rs2_id),
    .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id),
    .rd_id(rd_id), .regWrite_id(regWrite_id), .longOp_id(longOp_id),
    .rd_ex(rd_ex), .memRead_ex(memRead_ex), .branchTaken_ex(branchTaken_ex),
    .lop_wb_valid(lop_wb_valid), .lop_wb_rd(lop_wb_rd),
    .stallPC(stallPC), .stallIFID(stallIFID),
    .flushIFID(flushIFID), .flushIDEX(flushIDEX),
    .lop_busy(lop_busy), .pending(pending),
    .stall_cycles(stall_cycles), .lop_err(lop_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_busy = 1'b0;
    m_err  = 1'b0;
    m_cnt  = 0;
  endtask

  function automatic bit m_stall();
    bit lu, raw, waw, st;
    lu  = memRead_ex && rd_ex != 0 &&
          ((rs1_used_id && rs1_id == rd_ex) || (rs2_used_id && rs2_id == rd_ex));
    raw = (rs1_used_id && rs1_id != 0 && m_pend[rs1_id]) ||
          (rs2_used_id && rs2_id != 0 && m_pend[rs2_id]);
    waw = regWrite_id && rd_id != 0 && m_pend[rd_id];
    st  = longOp_id && m_busy;
    return lu || raw || waw || st;
  endfunction

  function automatic logic [31:0] m_pend_vec();
    logic [31:0] v = '0;
    for (int i = 0; i < 32; i++) v[i] = m_pend[i];
    return v;
  endfunction

  // Check every output mid-cycle, then advance the model across the edge.
  task automatic tick();
    bit s, br;
    @(negedge clk);
    s  = m_stall();
    br = branchTaken_ex;
    chk("stallPC",   stallPC,   !br && s);
    chk("stallIFID", stallIFID, !br && s);
    chk("flushIFID", flushIFID, br);
    chk("flushIDEX", flushIDEX, br || s);
    chk("lop_busy",  lop_busy,  m_busy);
    chk("pending",   pending,   m_pend_vec());
    chk("stall_cycles", stall_cycles, m_cnt);
    chk("lop_err",   lop_err,   m_err);
    @(posedge clk);
    if (lop_wb_valid) begin
      if (m_busy) begin
        m_busy = 1'b0;
        m_pend[lop_wb_rd] = 1'b0;
      end else m_err = 1'b1;
    end
    if (longOp_id && !s && !br) begin
      m_busy = 1'b1;
      if (regWrite_id && rd_id != 0) m_pend[rd_id] = 1'b1;
    end
    if (s && !br && m_cnt < CMAX) m_cnt++;
    #1;
  endtask

  task automatic idle();
    rs1_id = '0; rs2_id = '0; rd_id = '0; rd_ex = '0; lop_wb_rd = '0;
    rs1_used_id = 0; rs2_used_id = 0; regWrite_id = 0; longOp_id = 0;
    memRead_ex = 0; branchTaken_ex = 0; lop_wb_valid = 0;
  endtask

  task automatic set_id(input int a, input bit ua, input int b, input bit ub,
                        input int d, input bit wr, input bit lng);
    rs1_id = a[AW-1:0]; rs1_used_id = ua; rs2_id = b[AW-1:0]; rs2_used_id = ub;
    rd_id = d[AW-1:0]; regWrite_id = wr; longOp_id = lng;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    model_reset();
    #12;
    chk("reset_stallPC", stallPC, 0);
    chk("reset_flushIDEX", flushIDEX, 0);
    chk("reset_pending", pending, 0);
    chk("reset_busy", lop_busy, 0);
    chk("reset_cnt", stall_cycles, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // load x5 in EX, add x6,x5,x1 in ID
    memRead_ex = 1; rd_ex = 5; set_id(5, 1, 1, 1, 6, 1, 0);
    tick();
    chk("lu_stallPC_seen", m_cnt, 1);
    memRead_ex = 0;
    tick();
    chk("lu_cnt", stall_cycles, 1);
    chk("lu_released", stallPC, 0);
    // same case with rd=x0
    memRead_ex = 1; rd_ex = 0; set_id(0, 1, 1, 1, 6, 1, 0);
    tick();
    chk("lu_x0_nostall", stallPC, 0);
    idle();

    // div x7 at cycle 0, reader of x7 from cycle 1, writeback at cycle 10
    do_reset();
    set_id(1, 1, 2, 1, 7, 1, 1);
    tick();
    set_id(7, 1, 3, 1, 9, 1, 0);
    for (int c = 1; c <= 10; c++) begin
      lop_wb_valid = (c == 10); lop_wb_rd = 7;
      #1;
      chk("raw_stall", stallPC, 1);
      tick();
    end
    lop_wb_valid = 0;
    #1;
    chk("raw_release", stallPC, 0);
    chk("raw_pending7", pending[7], 0);
    tick();
    idle();

    // second MDU op waits behind the first; busy stays set from cycle 12
    do_reset();
    set_id(1, 1, 2, 1, 7, 1, 1);
    tick();
    set_id(3, 1, 4, 1, 8, 1, 1);
    for (int c = 1; c <= 10; c++) begin
      lop_wb_valid = (c == 10); lop_wb_rd = 7;
      tick();
    end
    lop_wb_valid = 0;
    #1;
    chk("struct_issue_cyc11", stallPC, 0);
    tick();
    idle();
    for (int c = 12; c < 15; c++) begin
      chk("struct_busy", lop_busy, 1);
      tick();
    end
    chk("struct_pend8", pending[8], 1);

    // load-use and branch together, MDU op in ID must not issue
    do_reset();
    memRead_ex = 1; rd_ex = 4; branchTaken_ex = 1; set_id(4, 1, 0, 0, 10, 1, 1);
    #1;
    chk("br_stallPC", stallPC, 0);
    chk("br_flushIFID", flushIFID, 1);
    tick();
    idle();
    tick();
    chk("br_no_issue", lop_busy, 0);
    chk("br_no_count", stall_cycles, 0);

    // randomized traffic
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      set_id($urandom_range(7), $urandom_range(1), $urandom_range(7), $urandom_range(1),
             $urandom_range(7), $urandom_range(1), $urandom_range(99) < 25);
      memRead_ex = $urandom_range(99) < 30;
      rd_ex = $urandom_range(7);
      branchTaken_ex = $urandom_range(99) < 10;
      lop_wb_valid = m_busy ? ($urandom_range(99) < 15) : ($urandom_range(99) < 1);
      lop_wb_rd = $urandom_range(7);
      tick();
    end
    idle();

    // stray writeback sets sticky error, scoreboard untouched
    do_reset();
    lop_wb_valid = 1; lop_wb_rd = 3;
    tick();
    lop_wb_valid = 0;
    for (int c = 0; c < 5; c++) tick();
    chk("err_sticky", lop_err, 1);
    chk("err_busy", lop_busy, 0);

    // structural stall held long enough to saturate the counter
    do_reset();
    chk("err_cleared", lop_err, 0);
    set_id(0, 0, 0, 0, 9, 1, 1);
    tick();
    for (int c = 0; c < CMAX - 1; c++) tick();
    chk("sat_preset", stall_cycles, CMAX - 1);
    for (int c = 0; c < 3; c++) tick();
    chk("sat_hold", stall_cycles, CMAX);

    // async reset between edges
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_busy", lop_busy, 0);
    chk("async_pending", pending, 0);
    chk("async_cnt", stall_cycles, 0);
    chk("async_err", lop_err, 0);
    model_reset();
    idle();
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
